// File: rtl/shift_reg_32bits_pkg.sv
// Shared definitions for the shift_reg_32bits universal shift register:
// the mode-select encoding on S and the default register width.
package shift_reg_32bits_pkg;

    // Default register width in bits.
    localparam int DEFAULT_WIDTH = 32;

    // Mode-select encoding carried on S.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Same encoding as an enum for readable debug views of S.
    typedef enum logic [1:0] {
        M_HOLD = 2'b00,
        M_SHR  = 2'b01,
        M_SHL  = 2'b10,
        M_LOAD = 2'b11
    } mode_e;

endpackage : shift_reg_32bits_pkg

// File: rtl/shift_reg_32bits_cell.sv
// shift_reg_cell: one bit of the universal shift register.
// A 4:1 mux picks hold / right-neighbour / left-neighbour / load data,
// and a flop with asynchronous active-low clear stores the result.
// Any S value other than the three active codes (including X/Z in
// simulation) falls through to the default arm and holds.
module shift_reg_cell
    import shift_reg_32bits_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       shr_in,   // bit arriving when shifting right
    input  logic       shl_in,   // bit arriving when shifting left
    input  logic       load_in,  // parallel load bit
    output logic       q
);

    logic bit_d;
    logic bit_q;

    // Next-state mux; anything unrecognised on sel keeps the stored bit.
    always_comb begin
        bit_d = bit_q;
        case (sel)
            MODE_HOLD: bit_d = bit_q;
            MODE_SHR:  bit_d = shr_in;
            MODE_SHL:  bit_d = shl_in;
            MODE_LOAD: bit_d = load_in;
            default:   bit_d = bit_q;
        endcase
    end

    // Storage flop; clear wins immediately, release takes effect on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule : shift_reg_cell

// File: rtl/shift_reg_32bits.sv
// shift_reg_32bits: WIDTH-bit universal shift register (hold, shift right,
// shift left, parallel load) with asynchronous active-low reset.
// Built from WIDTH shift_reg_cell instances; this level only wires each
// cell to its neighbours and to the serial inputs at the two ends.
// Optional feature: define SHIFT_REG_32BITS_ROTATE_EN to turn the shifts
// into rotates (the bit leaving one end re-enters the other, SL/SR unused).
// Q comes straight from the cell flops, so there is no input-to-output
// combinational path. WIDTH must be at least 2.
module shift_reg_32bits
    import shift_reg_32bits_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SL,
    input  logic             SR,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic             msb_feed;
    logic             lsb_feed;

`ifdef SHIFT_REG_32BITS_ROTATE_EN
    // Rotate build: the end bits feed each other; serial inputs are ignored.
    logic serial_unused;
    assign serial_unused = SL ^ SR;
    assign msb_feed      = q_bits[0];
    assign lsb_feed      = q_bits[WIDTH-1];
`else
    // Plain shift build: SR enters at the top, SL at the bottom.
    assign msb_feed = SR;
    assign lsb_feed = SL;
`endif

    // Neighbour wiring: right shift pulls from the bit above, left from below.
    always_comb begin
        shr_src = {msb_feed, q_bits[WIDTH-1:1]};
        shl_src = {q_bits[WIDTH-2:0], lsb_feed};
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            shift_reg_cell u_cell (
                .clk     (CLK),
                .rst_n   (RST),
                .sel     (S),
                .shr_in  (shr_src[i]),
                .shl_in  (shl_src[i]),
                .load_in (D[i]),
                .q       (q_bits[i])
            );
        end
    endgenerate

    assign Q = q_bits;

endmodule : shift_reg_32bits

// File: tb/tb_shift_reg_32bits.sv
// Self-checking bench for shift_reg_32bits (default WIDTH = 32).
// Compile with +define+SHIFT_REG_32BITS_ROTATE_EN to check the rotate build.
module tb_shift_reg_32bits;

    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         SL;
    logic         SR;
    logic [1:0]   S;
    logic [W-1:0] D;
    logic [W-1:0] Q;

    int checks;
    int failures;
    logic [W-1:0] model;

    shift_reg_32bits #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .SL  (SL),
        .SR  (SR),
        .S   (S),
        .D   (D),
        .Q   (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: what the register should hold after one edge, from the mode rules.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic [1:0] s,
                                              input logic [W-1:0] d, input logic sl, input logic sr);
        logic [W-1:0] top_bit;
        logic [W-1:0] low_bit;
`ifdef SHIFT_REG_32BITS_ROTATE_EN
        top_bit = {{(W-1){1'b0}}, cur[0]} << (W-1);
        low_bit = {{(W-1){1'b0}}, cur[W-1]};
`else
        top_bit = {{(W-1){1'b0}}, sr} << (W-1);
        low_bit = {{(W-1){1'b0}}, sl};
`endif
        case (s)
            2'd1:    return (cur >> 1) | top_bit;
            2'd2:    return (cur << 1) | low_bit;
            2'd3:    return d;
            default: return cur;
        endcase
    endfunction

    // Apply current inputs across one rising edge, update model, sample 1 time unit later.
    task automatic clock_edge();
        @(posedge CLK);
        if (RST) model = ref_next(model, S, D, SL, SR);
        else     model = '0;
        #1;
    endtask

    task automatic load_value(input logic [W-1:0] v);
        S = 2'b11; D = v;
        clock_edge();
    endtask

    task automatic test_reset();
        RST = 1'b1; S = 2'b11; D = '1; SL = 1'b0; SR = 1'b0;
        #2;
        RST = 1'b0;
        model = '0;
        #1;
        checks++;
        if (Q !== 32'h0000_0000) begin
            failures++;
            $display("FAIL reset_immediate: Q=%h expected %h", Q, 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            clock_edge();
            checks++;
            if (Q !== 32'h0000_0000) begin
                failures++;
                $display("FAIL reset_hold_%0d: Q=%h expected %h", k, Q, 32'h0);
            end
        end
        RST = 1'b1;
        clock_edge();
        checks++;
        if (Q !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_release: Q=%h expected %h", Q, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_load_hold();
        load_value(32'hA5A5_A5A5);
        checks++;
        if (Q !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL load: Q=%h expected %h", Q, 32'hA5A5_A5A5);
        end
        S = 2'b00; D = 32'h1234_5678; SL = 1'b1; SR = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clock_edge();
            checks++;
            if (Q !== 32'hA5A5_A5A5) begin
                failures++;
                $display("FAIL hold_%0d: Q=%h expected %h", k, Q, 32'hA5A5_A5A5);
            end
        end
    endtask

    task automatic test_shift_right();
        load_value(32'h8000_0001);
        S = 2'b01; SR = 1'b1; SL = 1'b1; D = 32'h0;
        clock_edge();
        checks++;
        if (Q !== 32'hC000_0000) begin
            failures++;
            $display("FAIL shift_right: Q=%h expected %h", Q, 32'hC000_0000);
        end
    endtask

    task automatic test_shift_left();
        logic [W-1:0] exp_q;
`ifdef SHIFT_REG_32BITS_ROTATE_EN
        exp_q = 32'h0000_0003;
`else
        exp_q = 32'h0000_0002;
`endif
        load_value(32'h8000_0001);
        S = 2'b10; SL = 1'b0; SR = 1'b1;
        clock_edge();
        checks++;
        if (Q !== exp_q) begin
            failures++;
            $display("FAIL shift_left: Q=%h expected %h", Q, exp_q);
        end
    endtask

    task automatic test_async_reset();
        load_value(32'hFFFF_FFFF);
        S = 2'b10; SL = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model = '0;
        #1;
        checks++;
        if (Q !== 32'h0000_0000) begin
            failures++;
            $display("FAIL async_reset: Q=%h expected %h", Q, 32'h0);
        end
        RST = 1'b1;
        SL = 1'b0;
        clock_edge();
        checks++;
        if (Q !== 32'h0000_0000) begin
            failures++;
            $display("FAIL async_reset_after: Q=%h expected %h", Q, 32'h0);
        end
    endtask

    task automatic test_fill();
        logic [W-1:0] exp_fill;
        logic [W-1:0] exp_drain;
`ifdef SHIFT_REG_32BITS_ROTATE_EN
        exp_fill  = 32'h0000_0000;
        exp_drain = 32'h0000_0000;
`else
        exp_fill  = 32'hFFFF_FFFF;
        exp_drain = 32'h0000_0000;
`endif
        load_value(32'h0);
        S = 2'b10; SL = 1'b1; SR = 1'b0;
        for (int k = 0; k < W; k++) begin
            clock_edge();
            checks++;
            if (Q !== model) begin
                failures++;
                $display("FAIL fill_step_%0d: Q=%h expected %h", k, Q, model);
            end
        end
        checks++;
        if (Q !== exp_fill) begin
            failures++;
            $display("FAIL fill_full: Q=%h expected %h", Q, exp_fill);
        end
        S = 2'b01; SR = 1'b0; SL = 1'b1;
        for (int k = 0; k < W; k++) begin
            clock_edge();
        end
        checks++;
        if (Q !== exp_drain) begin
            failures++;
            $display("FAIL fill_drain: Q=%h expected %h", Q, exp_drain);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            S  = 2'($urandom_range(0, 3));
            D  = $urandom;
            SL = 1'($urandom_range(0, 1));
            SR = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                RST = 1'b0;
                model = '0;
                #1;
                checks++;
                if (Q !== model) begin
                    failures++;
                    $display("FAIL random_reset_%0d: Q=%h expected %h", k, Q, model);
                end
                RST = 1'b1;
            end
            clock_edge();
            checks++;
            if (Q !== model) begin
                failures++;
                $display("FAIL random_%0d: S=%b Q=%h expected %h", k, S, Q, model);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model = '0;
        test_reset();
        test_load_hold();
        test_shift_right();
        test_shift_left();
        test_async_reset();
        test_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_reg_32bits

// File: doc/shift_reg_32bits.md
SHIFT_REG_32BITS -- requirements
Module: shift_reg_32bits

Interface
REQ-001 Parameter WIDTH, default 32, register width in bits; all vector ports are sized by it.
REQ-002 CLK  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-low.
REQ-004 SL  input  1  serial data in for shift-left; enters Q[0].
REQ-005 SR  input  1  serial data in for shift-right; enters Q[WIDTH-1].
REQ-006 S  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 D  input  WIDTH  parallel load data.
REQ-008 Q  output  WIDTH  register contents, driven directly from flops with no combinational path from inputs.

Function
REQ-009 S=00: Q SHALL retain its value.
REQ-010 S=01: next Q SHALL be {SR, Q[WIDTH-1:1]}.
REQ-011 S=10: next Q SHALL be {Q[WIDTH-2:0], SL}.
REQ-012 S=11: next Q SHALL be D.
REQ-013 Latency SHALL be one clock edge; the S, D, SL and SR values sampled at edge n appear on Q after edge n.
REQ-014 SL SHALL be ignored in every mode except 10, and SR in every mode except 01.
REQ-015 X or Z on S SHALL be treated as hold (S=00).
REQ-016 Shift-out bits are discarded; no wrap-around occurs unless REQ-021 is enabled.

Reset
REQ-017 While RST=0, Q SHALL be all zeros immediately, independent of CLK.
REQ-018 Reset SHALL override every mode, including a load or shift in progress.
REQ-019 Deassertion SHALL be synchronous; the first rising CLK edge with RST=1 performs the operation selected by S.

Configuration
REQ-020 Macro SHIFT_REG_32BITS_ROTATE_EN selects the rotate feature.
REQ-021 With the macro defined: S=01 SHALL produce {Q[0], Q[WIDTH-1:1]} and S=10 SHALL produce {Q[WIDTH-2:0], Q[WIDTH-1]}; SL and SR are ignored.
REQ-022 With the macro undefined: the design SHALL behave per REQ-010 and REQ-011; the ports are identical in both builds.

Structure
REQ-023 Package shift_reg_32bits_pkg SHALL hold the mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10 and MODE_LOAD=2'b11, plus the default width constant 32.
REQ-024 A one-bit sub-module shift_reg_cell (4:1 mux plus flop with async active-low clear) SHALL be instantiated WIDTH times via generate.
REQ-025 The top level SHALL wire the neighbour bits, serial inputs and rotate feedback into the cells.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Reset: RST=0 with S=11, D=FFFFFFFF, clocks running -> Q=00000000 throughout; release RST -> Q=FFFFFFFF after the first edge.
- Load then hold: S=11, D=A5A5A5A5, one edge -> Q=A5A5A5A5; S=00 for 3 edges -> Q unchanged.
- Shift right: Q=80000001, S=01, SR=1, one edge -> Q=C0000000 (non-rotate build); rotate build -> Q=C0000000 from the Q[0]=1 feedback.
- Shift left: Q=80000001, S=10, SL=0, one edge -> Q=00000002; rotate build -> Q=00000003.
- Async reset mid-shift: Q=FFFFFFFF, S=10, pulse RST low between edges -> Q=00000000 immediately, before the next edge.
- Fill: Q=0, S=10, SL=1 for 32 edges -> Q=FFFFFFFF; then S=01, SR=0 for 32 edges -> Q=00000000.
